// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared stage state encoding, default payload widths and per-stage payload structs
package pipeline_pkg;
    typedef enum logic [1:0] {EMPTY, FULL1, FULL2} stage_state_t;
    localparam int PIPE_DATA_W = 64;
    localparam int PIPE_CTRL_W = 16;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_data_t;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
    } id_ex_data_t;
    typedef struct packed {
        logic [31:0] alu_out;
        logic [31:0] store_val;
    } ex_mem_data_t;
    typedef struct packed {
        logic [31:0] result;
        logic [31:0] pc;
    } mem_wb_data_t;
    typedef struct packed {
        logic       we;
        logic [1:0] wb_sel;
        logic       mem_rd;
        logic       mem_wr;
        logic [3:0] alu_ctrl;
        logic [4:0] rd;
        logic [1:0] rsvd;
    } stage_ctrl_t;
endpackage

// File: rtl/stage_stall_counter.sv
// stage_stall_counter: saturating event counter with synchronous clear
module stage_stall_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (inc && count != '1)
            count <= count + CNT_WIDTH'(1);
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised valid/ready pipeline register with flush, optional skid slot and stall counter
module pipe_stage_reg
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH = PIPE_DATA_W,
    parameter int CTRL_WIDTH = PIPE_CTRL_W,
    parameter int SKID       = 1,
    parameter int RESET_DATA = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    input  logic                  clear_stats,
    output logic [CNT_WIDTH-1:0]  stall_cycles
);
    logic                  rdy_en;
    logic                  in_xfer, out_xfer;
    logic                  ld_in_main, ld_in_skid, ld_skid_main;
    logic [DATA_WIDTH-1:0] main_data, skid_data;
    logic [CTRL_WIDTH-1:0] main_ctrl, skid_ctrl;

    // keeps in_ready low while reset is held and until the first edge after release
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n)
            rdy_en <= 1'b0;
        else
            rdy_en <= 1'b1;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    generate
        if (SKID != 0) begin : g_skid
            stage_state_t state;
            assign in_ready     = rdy_en && !flush && (state != FULL2);
            assign out_valid    = state != EMPTY;
            assign ld_in_main   = in_xfer && (state == EMPTY || out_xfer);
            assign ld_in_skid   = in_xfer && state == FULL1 && !out_xfer;
            assign ld_skid_main = !flush && state == FULL2 && out_xfer;
            always_ff @(posedge clock or negedge reset_n)
                if (!reset_n)
                    state <= EMPTY;
                else if (flush)
                    state <= EMPTY;
                else
                    case (state)
                        EMPTY:   state <= in_xfer ? FULL1 : EMPTY;
                        FULL1:   state <= (in_xfer == out_xfer) ? FULL1 : (in_xfer ? FULL2 : EMPTY);
                        FULL2:   state <= out_xfer ? FULL1 : FULL2;
                        default: state <= EMPTY;
                    endcase
        end else begin : g_noskid
            logic valid_q;
            assign in_ready     = rdy_en && !flush && (!valid_q || out_ready);
            assign out_valid    = valid_q;
            assign ld_in_main   = in_xfer;
            assign ld_in_skid   = 1'b0;
            assign ld_skid_main = 1'b0;
            always_ff @(posedge clock or negedge reset_n)
                if (!reset_n)
                    valid_q <= 1'b0;
                else if (flush)
                    valid_q <= 1'b0;
                else if (in_xfer)
                    valid_q <= 1'b1;
                else if (out_xfer)
                    valid_q <= 1'b0;
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            main_ctrl <= '0;
            skid_ctrl <= '0;
        end else if (flush) begin
            main_ctrl <= '0;
            skid_ctrl <= '0;
        end else begin
            if (ld_in_main)
                main_ctrl <= in_ctrl;
            else if (ld_skid_main)
                main_ctrl <= skid_ctrl;
            if (ld_in_skid)
                skid_ctrl <= in_ctrl;
        end

    // payload is left untouched by flush; only valid/control mark it dead
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            if (RESET_DATA != 0) begin
                main_data <= '0;
                skid_data <= '0;
            end
        end else begin
            if (ld_in_main)
                main_data <= in_data;
            else if (ld_skid_main)
                main_data <= skid_data;
            if (ld_in_skid)
                skid_data <= in_data;
        end

    assign out_data = main_data;
    assign out_ctrl = out_valid ? main_ctrl : '0;

    stage_stall_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (clear_stats),
        .inc     (out_valid && !out_ready && !flush),
        .count   (stall_cycles)
    );

    a_in_stable: assert property (@(posedge clock) disable iff (!reset_n)
        in_valid && !in_ready |=> !in_valid || ($stable(in_data) && $stable(in_ctrl)));
    a_ctrl_zero: assert property (@(posedge clock) disable iff (!reset_n)
        !out_valid |-> out_ctrl == '0);
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: SKID=0 (u0) and SKID=1 (u1) stages checked against a queue model plus directed literals
module tb_pipe_stage_reg;
    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        in_valid [2];
    logic        out_ready [2];
    logic        flush [2];
    logic        clear_stats [2];
    logic [63:0] in_data [2];
    logic [15:0] in_ctrl [2];
    logic        in_ready [2];
    logic        out_valid [2];
    logic [63:0] out_data [2];
    logic [15:0] out_ctrl [2];
    logic [3:0]  stall [2];
    int          errors = 0;
    int          checks = 0;
    logic [79:0] mq [2][$];
    int          ms [2];
    bit          m_rdy = 1'b0;

    always #5 clock = ~clock;

    pipe_stage_reg #(.SKID(0), .RESET_DATA(0), .CNT_WIDTH(4)) u0 (
        .clock(clock), .reset_n(reset_n), .flush(flush[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .in_data(in_data[0]), .in_ctrl(in_ctrl[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .out_ctrl(out_ctrl[0]), .clear_stats(clear_stats[0]), .stall_cycles(stall[0])
    );

    pipe_stage_reg #(.SKID(1), .RESET_DATA(1), .CNT_WIDTH(4)) u1 (
        .clock(clock), .reset_n(reset_n), .flush(flush[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .in_data(in_data[1]), .in_ctrl(in_ctrl[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .out_ctrl(out_ctrl[1]), .clear_stats(clear_stats[1]), .stall_cycles(stall[1])
    );

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // capacity 2 with skid, capacity 1 (pass-through when draining) without
    function automatic bit exp_ready(input int d);
        if (!m_rdy || flush[d])
            return 1'b0;
        return d == 1 ? mq[d].size() < 2 : (mq[d].size() == 0 || out_ready[d]);
    endfunction

    initial forever begin
        @(posedge clock or negedge reset_n);
        if (!reset_n) begin
            for (int d = 0; d < 2; d++) begin
                mq[d].delete();
                ms[d] = 0;
            end
            m_rdy = 1'b0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                bit acc, ov;
                acc = in_valid[d] && exp_ready(d);
                ov = mq[d].size() > 0;
                if (clear_stats[d])
                    ms[d] = 0;
                else if (ov && !out_ready[d] && !flush[d] && ms[d] < 15)
                    ms[d]++;
                if (flush[d])
                    mq[d].delete();
                else begin
                    if (ov && out_ready[d])
                        void'(mq[d].pop_front());
                    if (acc)
                        mq[d].push_back({in_ctrl[d], in_data[d]});
                end
            end
            m_rdy = 1'b1;
        end
    end

    always @(negedge clock)
        for (int d = 0; d < 2; d++) begin
            bit ov;
            ov = mq[d].size() > 0;
            chk($sformatf("u%0d in_ready", d), 80'(in_ready[d]), 80'(exp_ready(d)));
            chk($sformatf("u%0d out_valid", d), 80'(out_valid[d]), 80'(ov));
            if (ov)
                chk($sformatf("u%0d out_data", d), 80'(out_data[d]), 80'(mq[d][0][63:0]));
            chk($sformatf("u%0d out_ctrl", d), 80'(out_ctrl[d]), ov ? 80'(mq[d][0][79:64]) : 80'(0));
            chk($sformatf("u%0d stall", d), 80'(stall[d]), 80'(ms[d]));
        end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic drive(input int d, input bit v, input logic [63:0] x);
        in_valid[d] = v;
        in_data[d] = x;
        in_ctrl[d] = x[15:0] ^ 16'h5A5A;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            drive(d, 1'b0, 64'h0);
            out_ready[d] = 1'b1;
            flush[d] = 1'b0;
            clear_stats[d] = 1'b0;
        end
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst u%0d out_valid", d), 80'(out_valid[d]), 80'(0));
            chk($sformatf("rst u%0d in_ready", d), 80'(in_ready[d]), 80'(0));
            chk($sformatf("rst u%0d out_ctrl", d), 80'(out_ctrl[d]), 80'(0));
            chk($sformatf("rst u%0d stall", d), 80'(stall[d]), 80'(0));
        end
        chk("rst u1 out_data", 80'(out_data[1]), 80'(0));
        reset_n = 1'b1;
        #1 chk("release u1 in_ready before edge", 80'(in_ready[1]), 80'(0));
        tick();
        chk("release u0 in_ready", 80'(in_ready[0]), 80'(1));
        chk("release u1 in_ready", 80'(in_ready[1]), 80'(1));

        for (int i = 1; i <= 10; i++) begin
            drive(1, 1'b1, 64'(i));
            tick();
            chk($sformatf("stream data %0d", i), 80'(out_data[1]), 80'(i));
            chk($sformatf("stream ready %0d", i), 80'(in_ready[1]), 80'(1));
        end
        drive(1, 1'b0, 64'h0);
        tick();
        chk("stream drained", 80'(out_valid[1]), 80'(0));

        out_ready[1] = 1'b0;
        drive(1, 1'b1, 64'hA);
        tick();
        chk("bp A held", 80'(out_data[1]), 80'hA);
        drive(1, 1'b1, 64'hB);
        tick();
        chk("bp ready after B", 80'(in_ready[1]), 80'(0));
        drive(1, 1'b1, 64'hC);
        repeat (3) tick();
        chk("bp still A", 80'(out_data[1]), 80'hA);
        chk("bp stall", 80'(stall[1]), 80'(4));
        out_ready[1] = 1'b1;
        tick();
        chk("bp order B", 80'(out_data[1]), 80'hB);
        tick();
        chk("bp order C", 80'(out_data[1]), 80'hC);
        drive(1, 1'b0, 64'hC);
        tick();
        chk("bp drained", 80'(out_valid[1]), 80'(0));
        chk("bp stall kept", 80'(stall[1]), 80'(4));

        out_ready[1] = 1'b0;
        drive(1, 1'b1, 64'h1A);
        tick();
        drive(1, 1'b1, 64'h1B);
        tick();
        drive(1, 1'b1, 64'hD);
        flush[1] = 1'b1;
        #1 chk("flush blocks in_ready", 80'(in_ready[1]), 80'(0));
        tick();
        flush[1] = 1'b0;
        #1;
        chk("flush out_valid", 80'(out_valid[1]), 80'(0));
        chk("flush out_ctrl", 80'(out_ctrl[1]), 80'(0));
        chk("flush in_ready", 80'(in_ready[1]), 80'(1));
        tick();
        chk("flush D emerges", 80'(out_data[1]), 80'hD);
        chk("flush D ctrl", 80'(out_ctrl[1]), 80'(16'h000D ^ 16'h5A5A));
        out_ready[1] = 1'b1;
        drive(1, 1'b0, 64'hD);
        tick();
        chk("flush stall", 80'(stall[1]), 80'(5));

        out_ready[0] = 1'b0;
        drive(0, 1'b1, 64'hA);
        tick();
        chk("s0 A held", 80'(out_data[0]), 80'hA);
        chk("s0 full ready", 80'(in_ready[0]), 80'(0));
        drive(0, 1'b1, 64'hB);
        repeat (2) tick();
        chk("s0 still A", 80'(out_data[0]), 80'hA);
        chk("s0 stall", 80'(stall[0]), 80'(2));
        out_ready[0] = 1'b1;
        #1 chk("s0 ready follows out_ready hi", 80'(in_ready[0]), 80'(1));
        out_ready[0] = 1'b0;
        #1 chk("s0 ready follows out_ready lo", 80'(in_ready[0]), 80'(0));
        out_ready[0] = 1'b1;
        tick();
        chk("s0 order B", 80'(out_data[0]), 80'hB);
        drive(0, 1'b1, 64'hC);
        tick();
        chk("s0 order C", 80'(out_data[0]), 80'hC);
        drive(0, 1'b0, 64'hC);
        tick();
        chk("s0 drained", 80'(out_valid[0]), 80'(0));

        clear_stats[1] = 1'b1;
        tick();
        clear_stats[1] = 1'b0;
        chk("cnt cleared", 80'(stall[1]), 80'(0));
        out_ready[1] = 1'b0;
        drive(1, 1'b1, 64'hE);
        tick();
        drive(1, 1'b0, 64'hE);
        repeat (20) tick();
        chk("cnt saturates", 80'(stall[1]), 80'(15));
        clear_stats[1] = 1'b1;
        tick();
        chk("cnt clear beats stall", 80'(stall[1]), 80'(0));
        clear_stats[1] = 1'b0;
        tick();
        chk("cnt restarts", 80'(stall[1]), 80'(1));
        out_ready[1] = 1'b1;
        tick();
        chk("cnt drained", 80'(out_valid[1]), 80'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline stage register; the successor to the fixed per-stage fetch/decode/execute/memory/writeback registers.
- Carries a datapath vector and a control vector between stages under a valid/ready handshake.
- Adds synchronous flush (bubble insertion), back-pressure, and an optional skid slot that registers in_ready.
- Also keeps a saturating stall-cycle counter for performance debug.

Parameters:
- DATA_WIDTH, 64: width of datapath payload (pc, operands, immediates).
- CTRL_WIDTH, 16: width of control payload (we, sel, alu_ctrl bits).
- SKID, 1: 0 = single register with combinational in_ready; 1 = main register plus one skid slot, in_ready registered.
- RESET_DATA, 1: 1 = data registers cleared by reset; 0 = data registers not reset (control and valid always reset).
- CNT_WIDTH, 16: width of stall counter.

Ports:
- clock, input, 1: sole clock, rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- flush, input, 1: synchronous flush, highest priority.
- in_valid, input, 1: upstream has a word.
- in_ready, output, 1: stage accepts a word this cycle.
- in_data, input, DATA_WIDTH: upstream datapath payload.
- in_ctrl, input, CTRL_WIDTH: upstream control payload.
- out_valid, output, 1: stage holds a valid word.
- out_ready, input, 1: downstream accepts.
- out_data, output, DATA_WIDTH: registered datapath payload.
- out_ctrl, output, CTRL_WIDTH: registered control payload; forced to 0 whenever out_valid=0.
- clear_stats, input, 1: synchronous clear of stall_cycles.
- stall_cycles, output, CNT_WIDTH: saturating count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - Latency is 1 cycle from input transfer to out_valid when the stage is empty.
- Reset (reset_n low, asynchronous):
  - out_valid=0, out_ctrl=0, skid valid=0, stall_cycles=0.
  - out_data=0 and skid data=0 if RESET_DATA=1.
  - in_ready=0 while reset_n is low; in_ready=1 from the first rising edge after deassertion.
  - Reset mid-transfer discards all held words.
- SKID=0:
  - in_ready = rdy_en && !flush && (!out_valid || out_ready).
  - On input transfer, out_* loads in_*.
  - On output transfer without input transfer, out_valid clears.
- SKID=1 state machine (EMPTY, FULL1, FULL2):
  - EMPTY: out_valid=0, in_ready=1. Input transfer moves to FULL1.
  - FULL1: out_valid=1, in_ready=1.
    - Input and output transfer together: main reloads, stay FULL1.
    - Input transfer only: word goes to skid slot, move to FULL2.
    - Output transfer only: move to EMPTY.
  - FULL2: out_valid=1, in_ready=0 (registered).
    - Output transfer: skid word moves to main, move to FULL1.
  - in_ready = rdy_en && !flush && (state != FULL2). The flush term is the only combinational input on in_ready.
  - Ordering is strictly FIFO; no word is duplicated or dropped except by flush.
- Flush:
  - flush=1 at a rising edge: next state EMPTY, out_valid=0, out_ctrl=0, skid cleared.
  - Data registers hold their values (not cleared).
  - in_ready=0 in the same cycle, so a simultaneous in_valid is not accepted.
  - Flush overrides a simultaneous output transfer for register update. Downstream still sees the word it sampled that cycle; downstream-side squash is its own concern.
- stall_cycles:
  - Increments when out_valid && !out_ready && !flush.
  - Saturates at all ones.
  - clear_stats sets it to 0 and has priority over increment.
- Width rules:
  - No arithmetic on the payload.
  - Counter increment is unsigned CNT_WIDTH with saturation check before add.
- Assertions required:
  - in_data and in_ctrl are stable while in_valid && !in_ready (upstream contract).
  - out_ctrl == 0 whenever !out_valid.

Decomposition:
- pipeline_pkg gains:
  - typedef enum logic [1:0] stage_state_t {EMPTY, FULL1, FULL2}.
  - Default width constants PIPE_DATA_W and PIPE_CTRL_W.
  - Per-stage packed struct typedefs sized to those constants, so existing stages instantiate pipe_stage_reg via struct casts.
- One sub-module, stage_stall_counter: saturating counter with clear, parametrised by CNT_WIDTH.
- Skid logic stays inline under a generate on SKID.

Test Plan:
1. Reset and ready: reset_n low 3 cycles, then high → out_valid=0, out_ctrl=0, stall_cycles=0 during reset; in_ready=0 during reset and 1 the first cycle after.
2. Streaming: SKID=1, out_ready=1, in_valid=1 with data 1,2,3,…,10 → out_data 1..10 on consecutive cycles, 1-cycle latency, in_ready never drops.
3. Back-pressure: SKID=1, out_ready=0 while sending A,B,C →
   - A and B accepted; in_ready=0 the cycle after B; C held by upstream.
   - Releasing out_ready gives A,B,C in order.
   - stall_cycles equals the number of held cycles.
4. Flush with traffic: state FULL2 (A main, B skid), flush=1 with in_valid=1 data D →
   - Next cycle out_valid=0, out_ctrl=0, in_ready=1.
   - D not accepted; re-presented D emerges next.
5. SKID=0 build: repeat scenario 3 → only A held, in_ready=out_ready combinationally, order preserved.
6. Counter edges: CNT_WIDTH=4 with a 20-cycle stall → stall_cycles saturates at 15; clear_stats in the same cycle as a stall → 0.
